// File: rtl/bc_round_controller.sv
// Bulls and Cows round sequencer: answer generation/load, guess entry, check strobe, result hold, win/lose.
// Optional build macro DUP_REJECT_EN rejects guesses with repeated digits and adds the dup_err pulse.
module bc_round_controller #(
  parameter int          MAX_ATTEMPTS = 10,
  parameter int          HOLD_CYCLES  = 50000000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        answer_we,
  input  logic [15:0] answer_in,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        clear,
  input  logic [3:0]  strike,
  input  logic [3:0]  ball,
  output logic [15:0] answer,
  output logic [15:0] guess,
  output logic [2:0]  digit_cnt,
  output logic        check_en,
  output logic [3:0]  attempts,
  output logic [2:0]  state,
  output logic        win,
  output logic        lose,
  output logic        piezo_en,
  output logic        motor_en
`ifdef DUP_REJECT_EN
  ,
  output logic        dup_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_GEN = 3'd1, S_ENTRY = 3'd2, S_CHECK = 3'd3,
    S_WAIT = 3'd4, S_SHOW = 3'd5, S_WIN = 3'd6, S_LOSE = 3'd7
  } state_t;

  localparam int              HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [4:0]      MAX_ATT   = 5'(MAX_ATTEMPTS);

  state_t          st;
  logic [15:0]     lfsr;
  logic [2:0]      gen_cnt;
  logic [HC_W-1:0] hold_cnt;
  logic [3:0]      cand, att_next;
  logic [15:0]     guess_next;
  logic            lfsr_fb, cand_ok, last_att;
  logic            ball_unused;

  assign state       = st;
  assign ball_unused = ^ball;
  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign cand        = lfsr[3:0];
  // answer was zeroed on start, so only the nibbles already accepted take part in the uniqueness test
  assign cand_ok     = (cand <= 4'd9)
                     && !((gen_cnt >= 3'd1) && (answer[3:0]  == cand))
                     && !((gen_cnt >= 3'd2) && (answer[7:4]  == cand))
                     && !((gen_cnt >= 3'd3) && (answer[11:8] == cand));
  assign att_next    = (attempts == 4'hF) ? 4'hF : attempts + 4'd1;
  assign last_att    = ({1'b0, attempts} + 5'd1) == MAX_ATT;
  assign guess_next  = {guess[11:0], digit};

`ifdef DUP_REJECT_EN
  logic guess_dup;
  assign guess_dup = (guess_next[15:12] == guess_next[11:8]) || (guess_next[15:12] == guess_next[7:4])
                  || (guess_next[15:12] == guess_next[3:0])  || (guess_next[11:8]  == guess_next[7:4])
                  || (guess_next[11:8]  == guess_next[3:0])  || (guess_next[7:4]   == guess_next[3:0]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      lfsr      <= LFSR_SEED;
      gen_cnt   <= '0;
      hold_cnt  <= '0;
      answer    <= '0;
      guess     <= '0;
      digit_cnt <= '0;
      check_en  <= 1'b0;
      attempts  <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      piezo_en  <= 1'b0;
      motor_en  <= 1'b0;
`ifdef DUP_REJECT_EN
      dup_err   <= 1'b0;
`endif
    end else begin
      lfsr     <= {lfsr[14:0], lfsr_fb};
      check_en <= 1'b0;
`ifdef DUP_REJECT_EN
      dup_err  <= 1'b0;
`endif
      if (answer_we || start) begin
        guess     <= '0;
        digit_cnt <= '0;
        attempts  <= '0;
        win       <= 1'b0;
        lose      <= 1'b0;
        piezo_en  <= 1'b0;
        motor_en  <= 1'b0;
        hold_cnt  <= '0;
        gen_cnt   <= '0;
        answer    <= answer_we ? answer_in : 16'h0;
        st        <= answer_we ? S_ENTRY : S_GEN;
      end else begin
        case (st)
          S_GEN: if (cand_ok) begin
            answer  <= {answer[11:0], cand};
            gen_cnt <= gen_cnt + 3'd1;
            if (gen_cnt == 3'd3) st <= S_ENTRY;
          end
          S_ENTRY: begin
            if (clear) begin
              guess     <= '0;
              digit_cnt <= '0;
            end else if (digit_valid && (digit <= 4'd9)) begin
`ifdef DUP_REJECT_EN
              if ((digit_cnt == 3'd3) && guess_dup) begin
                guess     <= '0;
                digit_cnt <= '0;
                dup_err   <= 1'b1;
              end else
`endif
              begin
                guess     <= guess_next;
                digit_cnt <= digit_cnt + 3'd1;
                // strobe is registered so it lines up with the single CHECK cycle
                if (digit_cnt == 3'd3) begin
                  st       <= S_CHECK;
                  check_en <= 1'b1;
                end
              end
            end
          end
          S_CHECK: st <= S_WAIT;
          S_WAIT: begin
            attempts <= att_next;
            hold_cnt <= '0;
            if (strike == 4'd4) begin
              st       <= S_WIN;
              win      <= 1'b1;
              motor_en <= 1'b1;
              piezo_en <= 1'b1;
            end else if (last_att) begin
              st       <= S_LOSE;
              lose     <= 1'b1;
              motor_en <= 1'b0;
              piezo_en <= 1'b1;
            end else begin
              st <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (hold_cnt == HOLD_LAST) begin
              st        <= S_ENTRY;
              guess     <= '0;
              digit_cnt <= '0;
              hold_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          S_WIN, S_LOSE: if (piezo_en) begin
            if (hold_cnt == HOLD_LAST) piezo_en <= 1'b0;
            else                       hold_cnt <= hold_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
